// File: rtl/mem_arbiter.sv
// mem_arbiter: serializes the CPU instruction-fetch port (imem_*) and the
// data port (mem_*) onto a single downstream L2 port (l2_*).
//
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   imem_*              - instruction requester (request held until imem_resp)
//   mem_*               - data requester (request held until mem_resp)
//   l2_address/wdata/byte_enable/read/write - registered downstream request
//   l2_rdata, l2_resp   - downstream completion
//
// Data wins arbitration unless an instruction request has already watched
// STARVE_LIMIT consecutive data grants go by. Each transaction runs
// IDLE -> BUSY_x -> RESP -> IDLE, so back-to-back grants are 3+ cycles apart.
// Every output comes straight from a flop.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] imem_address,
  input  logic [15:0] imem_wdata,
  input  logic        imem_read,
  input  logic        imem_write,
  input  logic [1:0]  imem_byte_enable,
  output logic [15:0] imem_rdata,
  output logic        imem_resp,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_byte_enable,
  output logic [15:0] mem_rdata,
  output logic        mem_resp,
  output logic [15:0] l2_address,
  output logic [15:0] l2_wdata,
  output logic [1:0]  l2_byte_enable,
  output logic        l2_read,
  output logic        l2_write,
  input  logic [15:0] l2_rdata,
  input  logic        l2_resp
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_t           state, state_n;
  logic             owner_d;   // 1: data port owns the in-flight access
  logic [CNT_W-1:0] cnt;       // data grants made while I was waiting
  logic             i_pend, d_pend;
  logic             grant_i, grant_d;
  logic             done;      // L2 completion accepted this cycle

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    i_pend  = imem_read | imem_write;
    d_pend  = mem_read | mem_write;
    grant_i = 1'b0;
    grant_d = 1'b0;
    done    = 1'b0;
    state_n = state;
    case (state)
      IDLE: begin
        if (d_pend && (!i_pend || cnt < LIMIT)) begin
          grant_d = 1'b1;
          state_n = BUSY_D;
        end else if (i_pend) begin
          grant_i = 1'b1;
          state_n = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (l2_resp) begin
          done    = 1'b1;
          state_n = RESP;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      l2_address     <= '0;
      l2_wdata       <= '0;
      l2_byte_enable <= '0;
      l2_read        <= 1'b0;
      l2_write       <= 1'b0;
      imem_rdata     <= '0;
      mem_rdata      <= '0;
      imem_resp      <= 1'b0;
      mem_resp       <= 1'b0;
      owner_d        <= 1'b1;
      cnt            <= '0;
    end else begin
      // resp is a single-cycle pulse; only a completion re-arms it
      imem_resp <= 1'b0;
      mem_resp  <= 1'b0;

      if (grant_d) begin
        l2_address     <= mem_address;
        l2_wdata       <= mem_wdata;
        l2_byte_enable <= mem_byte_enable;
        // read+write together is a write
        l2_write       <= mem_write;
        l2_read        <= mem_read & ~mem_write;
        owner_d        <= 1'b1;
        if (!i_pend)          cnt <= '0;
        else if (cnt != LIMIT) cnt <= cnt + 1'b1;
      end else if (grant_i) begin
        l2_address     <= imem_address;
        l2_wdata       <= imem_wdata;
        l2_byte_enable <= imem_byte_enable;
        l2_write       <= imem_write;
        l2_read        <= imem_read & ~imem_write;
        owner_d        <= 1'b0;
        cnt            <= '0;
      end

      if (done) begin
        l2_read  <= 1'b0;
        l2_write <= 1'b0;
        if (owner_d) begin
          mem_rdata <= l2_rdata;
          mem_resp  <= 1'b1;
        end else begin
          imem_rdata <= l2_rdata;
          imem_resp  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] imem_address, imem_wdata, imem_rdata;
  logic        imem_read, imem_write, imem_resp;
  logic [1:0]  imem_byte_enable;
  logic [15:0] mem_address, mem_wdata, mem_rdata;
  logic        mem_read, mem_write, mem_resp;
  logic [1:0]  mem_byte_enable;
  logic [15:0] l2_address, l2_wdata, l2_rdata;
  logic [1:0]  l2_byte_enable;
  logic        l2_read, l2_write, l2_resp;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .imem_address(imem_address), .imem_wdata(imem_wdata),
    .imem_read(imem_read), .imem_write(imem_write),
    .imem_byte_enable(imem_byte_enable), .imem_rdata(imem_rdata),
    .imem_resp(imem_resp),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_rdata(mem_rdata),
    .mem_resp(mem_resp),
    .l2_address(l2_address), .l2_wdata(l2_wdata),
    .l2_byte_enable(l2_byte_enable), .l2_read(l2_read), .l2_write(l2_write),
    .l2_rdata(l2_rdata), .l2_resp(l2_resp)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change and outputs are observed on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    imem_address = '0; imem_wdata = '0; imem_read = 0; imem_write = 0; imem_byte_enable = '0;
    mem_address  = '0; mem_wdata  = '0; mem_read  = 0; mem_write  = 0; mem_byte_enable  = '0;
    l2_rdata = '0; l2_resp = 0;
    step(); step();
    reset = 1'b0;
    step();

    // reset state
    chk("rst_l2_read",  16'(l2_read), 16'd0);
    chk("rst_l2_write", 16'(l2_write), 16'd0);
    chk("rst_l2_addr",  l2_address, 16'h0000);
    chk("rst_resp",     16'({imem_resp, mem_resp}), 16'd0);
    chk("rst_rdata",    imem_rdata | mem_rdata, 16'h0000);
    chk("rst_cnt",      16'(dut.cnt), 16'd0);

    // single I read, L2 answers in the 2nd busy cycle
    imem_read = 1; imem_address = 16'h0040; imem_byte_enable = 2'b11;
    step();
    chk("i1_l2_read", 16'(l2_read), 16'd1);
    chk("i1_l2_addr", l2_address, 16'h0040);
    imem_address = 16'hFFFF;            // late change must not reach l2
    step();
    chk("i1_hold_read", 16'(l2_read), 16'd1);
    chk("i1_hold_addr", l2_address, 16'h0040);
    l2_resp = 1; l2_rdata = 16'h1234;
    step();
    l2_resp = 0; imem_read = 0;
    chk("i1_resp",   16'(imem_resp), 16'd1);
    chk("i1_rdata",  imem_rdata, 16'h1234);
    chk("i1_mresp",  16'(mem_resp), 16'd0);
    chk("i1_drop",   16'(l2_read), 16'd0);
    step();
    chk("i1_pulse",  16'(imem_resp), 16'd0);

    // simultaneous I read and D write: data first
    imem_read = 1; imem_address = 16'h0100;
    mem_write = 1; mem_address = 16'h2000; mem_wdata = 16'hBEEF; mem_byte_enable = 2'b01;
    step();
    chk("sim_d_write", 16'(l2_write), 16'd1);
    chk("sim_d_read",  16'(l2_read), 16'd0);
    chk("sim_d_addr",  l2_address, 16'h2000);
    chk("sim_d_wdata", l2_wdata, 16'hBEEF);
    chk("sim_d_be",    16'(l2_byte_enable), 16'd1);
    l2_resp = 1; l2_rdata = 16'h0F0F;
    step();
    l2_resp = 0; mem_write = 0;
    chk("sim_mresp",   16'(mem_resp), 16'd1);
    chk("sim_iresp",   16'(imem_resp), 16'd0);
    chk("sim_irdata",  imem_rdata, 16'h1234);
    step();                               // IDLE: grant evaluated here
    chk("sim_no_early", 16'(l2_read | l2_write), 16'd0);
    step();
    chk("sim_i_read",  16'(l2_read), 16'd1);
    chk("sim_i_addr",  l2_address, 16'h0100);
    l2_resp = 1; l2_rdata = 16'h5555;
    step();
    l2_resp = 0; imem_read = 0;
    chk("sim_i_resp",  16'(imem_resp), 16'd1);
    chk("sim_i_rdata", imem_rdata, 16'h5555);
    step();

    // starvation: I held, D back-to-back; 4 D grants then I
    imem_read = 1; imem_address = 16'h0300;
    mem_read = 1;  mem_address = 16'h4000;
    for (int g = 0; g < 5; g++) begin
      step();
      chk($sformatf("stv_addr%0d", g), l2_address, (g < 4) ? 16'h4000 : 16'h0300);
      chk($sformatf("stv_cnt%0d", g), 16'(dut.cnt), (g < 4) ? 16'(g + 1) : 16'd0);
      l2_resp = 1; l2_rdata = 16'(16'h0A00 + g);
      step();
      l2_resp = 0;
      chk($sformatf("stv_mresp%0d", g), 16'(mem_resp), (g < 4) ? 16'd1 : 16'd0);
      chk($sformatf("stv_iresp%0d", g), 16'(imem_resp), (g < 4) ? 16'd0 : 16'd1);
      if (g == 4) begin imem_read = 0; mem_read = 0; end
      step();
    end

    // read+write both high on data port is a write
    mem_read = 1; mem_write = 1; mem_address = 16'h5000;
    step();
    chk("rw_write", 16'(l2_write), 16'd1);
    chk("rw_read",  16'(l2_read), 16'd0);
    l2_resp = 1;
    step();
    l2_resp = 0; mem_read = 0; mem_write = 0;
    chk("rw_mresp", 16'(mem_resp), 16'd1);
    step();

    // reset while BUSY_D
    mem_write = 1; mem_address = 16'h6000;
    step();
    chk("rb_busy", 16'(l2_write), 16'd1);
    reset = 1; mem_write = 0;
    step();
    reset = 0;
    chk("rb_drop",  16'(l2_write), 16'd0);
    chk("rb_mresp", 16'(mem_resp), 16'd0);
    l2_resp = 1; l2_rdata = 16'hDEAD;    // stale completion in IDLE
    step();
    l2_resp = 0;
    chk("rb_stale_strobe", 16'(l2_read | l2_write), 16'd0);
    step();
    chk("rb_stale_resp", 16'({imem_resp, mem_resp}), 16'd0);
    chk("rb_stale_rdata", mem_rdata, 16'h0000);
    imem_read = 1; imem_address = 16'h0700;
    step();
    chk("rb_i_read", 16'(l2_read), 16'd1);
    chk("rb_i_addr", l2_address, 16'h0700);
    l2_resp = 1; l2_rdata = 16'hA5A5;
    step();
    l2_resp = 0; imem_read = 0;
    chk("rb_i_resp",  16'(imem_resp), 16'd1);
    chk("rb_i_rdata", imem_rdata, 16'hA5A5);
    step();

    // zero-wait L2 with continuous D reads: one grant every 3 cycles
    mem_read = 1; mem_address = 16'h7000;
    for (int k = 1; k <= 9; k++) begin
      step();
      chk($sformatf("zw_read%0d", k), 16'(l2_read), (k % 3 == 1) ? 16'd1 : 16'd0);
      chk($sformatf("zw_mresp%0d", k), 16'(mem_resp), (k % 3 == 2) ? 16'd1 : 16'd0);
      if (k % 3 == 1) chk($sformatf("zw_addr%0d", k), l2_address, 16'h7000);
      if (k % 3 == 2) chk($sformatf("zw_rdata%0d", k), mem_rdata, 16'(16'h3000 + k - 1));
      l2_resp  = (k % 3 == 1);
      l2_rdata = 16'(16'h3000 + k);
    end
    mem_read = 0; l2_resp = 0;
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Responder for the CPU's two memory ports (imem_* instruction fetch, mem_* data/MEM stage). Sits between the pipelined CPU and the L2 cache.
- Accepts one word-level request at a time, serializes instruction and data requests onto a single downstream l2_* port, and returns rdata/resp to the requester.
- Data requests have priority. A starvation counter guarantees forward progress for instruction fetch.

Parameters:
- STARVE_LIMIT, 4: consecutive data grants made while an instruction request is waiting; once reached, the next grant goes to instruction.
- CNT_W, 3: width of the starvation counter; must hold STARVE_LIMIT.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- imem_address  in  16  instruction request address
- imem_wdata  in  16  instruction write data
- imem_read  in  1  instruction read request, held until imem_resp
- imem_write  in  1  instruction write request, held until imem_resp
- imem_byte_enable  in  2  instruction byte enables
- imem_rdata  out  16  instruction read data, valid with imem_resp
- imem_resp  out  1  one-cycle completion pulse to instruction port
- mem_address  in  16  data request address
- mem_wdata  in  16  data write data
- mem_read  in  1  data read request, held until mem_resp
- mem_write  in  1  data write request, held until mem_resp
- mem_byte_enable  in  2  data byte enables
- mem_rdata  out  16  data read data, valid with mem_resp
- mem_resp  out  1  one-cycle completion pulse to data port
- l2_address  out  16  downstream address (registered)
- l2_wdata  out  16  downstream write data (registered)
- l2_byte_enable  out  2  downstream byte enables (registered)
- l2_read  out  1  downstream read strobe, held until l2_resp
- l2_write  out  1  downstream write strobe, held until l2_resp
- l2_rdata  in  16  downstream read data, valid with l2_resp
- l2_resp  in  1  downstream completion

Behaviour:
- States: IDLE, BUSY_I, BUSY_D, RESP.
- Reset values: state IDLE; all l2_* outputs 0; imem_resp and mem_resp 0; imem_rdata and mem_rdata 0; starvation counter 0; owner=D.

IDLE:
- Port pending = read|write. If both read and write are high on a port, treat it as a write.
- Grant D if D is pending and (I is not pending or counter < STARVE_LIMIT).
- Otherwise grant I if I is pending.
- On grant:
  - Latch address, wdata and byte_enable into the l2 registers.
  - Set l2_read or l2_write.
  - Record the owner.
  - Go to BUSY_D or BUSY_I.
- Request seen in cycle N gives l2 strobe high in cycle N+1.

Starvation counter (updated at grant time only):
- D grant while I is pending: counter+1, saturating at STARVE_LIMIT.
- Any I grant: clear to 0.
- D grant with I not pending: clear to 0.

BUSY_x:
- Hold all l2 outputs stable until l2_resp=1.
- l2_resp=1 in cycle M:
  - Capture l2_rdata into the owner's rdata register. Capture it on writes too; its value is don't-care.
  - Drop the l2 strobe at M+1.
  - Go to RESP.

RESP:
- Owner's resp=1 for exactly cycle M+1; the other resp stays 0.
- Non-owner rdata keeps its previous value.
- Next state is IDLE unconditionally. No grant is made in RESP, so the earliest next grant is evaluated in M+2.
- Minimum turnaround per transaction: 3 cycles, with l2_resp in the first BUSY cycle.

Other rules:
- A requester that drops its request while its transaction is in flight: the downstream access still completes, and the resp pulse is still issued (harmless).
- l2_resp while in IDLE or RESP: ignored.
- Reset mid-transaction: return to IDLE, l2 strobes drop next cycle, the pending resp is lost. The outstanding L2 completion is ignored.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- Single I read: imem_read=1, addr 0x0040, l2_resp after 2 cycles with rdata 0x1234 -> l2_read=1 with l2_address=0x0040 the cycle after the request; imem_resp=1 and imem_rdata=0x1234 for exactly one cycle; mem_resp stays 0.
- Simultaneous request: imem_read@0x0100 and mem_write@0x2000 (wdata 0xBEEF, be=2'b01) raised together -> data granted first with l2_write, l2_wdata=0xBEEF, l2_byte_enable=01; the I read is issued only after mem_resp plus the RESP cycle.
- Starvation: imem_read held while data requests arrive back-to-back, STARVE_LIMIT=4 -> exactly 4 data grants, then the I grant; counter reads 0 after the I grant.
- Read+write both high on the data port -> treated as a write (l2_write=1, l2_read=0).
- Reset in BUSY_D (l2_write high) -> l2_write=0 next cycle, no mem_resp. A later l2_resp is ignored, and the next imem_read is served normally.
- Zero-wait L2 (l2_resp in the first BUSY cycle) with continuous D reads -> one grant every 3 cycles; l2 outputs are stable throughout each BUSY period.
